// File: rtl/alu_pkg.sv
// Shared definitions for the three-bit ALU datapath.
//   - state_t : operand-loader FSM states (value doubles as the LED code)
//   - op_t    : operation codes decoded by the downstream result mux
//   - ALU_W / RES_W / OP_W : operand, result and op-select widths
package alu_pkg;
  localparam int ALU_W = 3;
  localparam int RES_W = 6;
  localparam int OP_W  = 2;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } op_t;
endpackage

// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, level debouncer and
// press-pulse generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_n      : raw button, low when pressed, asynchronous and bouncing
//   press      : one-cycle pulse when the debounced level becomes pressed
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          key_sync;
  logic          key_stable;
  logic [CW-1:0] cnt;
  logic [1:0]    flush;
  logic          armed;

  assign key_sync = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_n};
  end

  // The synchroniser resets to "released", so a key held through reset
  // would look like a fresh press. Pulses are only allowed once a genuine
  // released level has been seen after the synchroniser has flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_stable <= 1'b1;
      cnt        <= '0;
      press      <= 1'b0;
      flush      <= 2'b00;
      armed      <= 1'b0;
    end else begin
      press <= 1'b0;
      flush <= {flush[0], 1'b1};
      if (flush[1] && key_sync && key_stable) armed <= 1'b1;
      if (key_sync == key_stable) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        key_stable <= key_sync;
        cnt        <= '0;
        press      <= armed & ~key_sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/operand_loader.sv
// Front end of the switch-driven ALU: one button press per value loads
// operand A, operand B, then the op select, and holds them with a valid flag.
//   clk, rst_n     : clock, asynchronous active-low reset
//   sw, op_sw      : quasi-static switches (operand / operation select)
//   key_n          : raw push button, low when pressed
//   a, b, op       : registered operands and operation
//   operands_valid : high while a/b/op form a complete set (READY)
//   state_led      : FSM state code for the LEDs
module operand_loader
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ALU_W-1:0] sw,
  input  logic [OP_W-1:0]  op_sw,
  input  logic             key_n,
  output logic [ALU_W-1:0] a,
  output logic [ALU_W-1:0] b,
  output logic [OP_W-1:0]  op,
  output logic             operands_valid,
  output logic [1:0]       state_led
);
  logic [ALU_W-1:0] sw_s1, sw_s2;
  logic [OP_W-1:0]  op_s1, op_s2;
  logic             press;
  state_t           state, state_nxt;
  logic             cap_a, cap_b, cap_op, clr_v;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (press)
  );

  // Switches are quasi-static; a 2-flop stage is enough to keep the
  // captured word coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      op_s1 <= '0;
      op_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      op_s1 <= op_sw;
      op_s2 <= op_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    cap_op    = 1'b0;
    clr_v     = 1'b0;
    if (press) begin
      unique case (state)
        WAIT_A:  begin cap_a  = 1'b1; state_nxt = WAIT_B;  end
        WAIT_B:  begin cap_b  = 1'b1; state_nxt = WAIT_OP; end
        WAIT_OP: begin cap_op = 1'b1; state_nxt = READY;   end
        READY:   begin clr_v  = 1'b1; state_nxt = WAIT_A;  end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a              <= '0;
      b              <= '0;
      op             <= '0;
      operands_valid <= 1'b0;
    end else begin
      if (cap_a) a <= sw_s2;
      if (cap_b) b <= sw_s2;
      if (cap_op) begin
        op             <= op_s2;
        operands_valid <= 1'b1;
      end
      if (clr_v) operands_valid <= 1'b0;
    end
  end

  assign state_led = state;
endmodule

// File: tb/tb_operand_loader.sv
// Randomised scoreboard bench for operand_loader (DEBOUNCE_CYCLES = 4).
module tb_operand_loader;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic [2:0] sw;
  logic [1:0] op_sw;
  logic [2:0] a, b;
  logic [1:0] op;
  logic       operands_valid;
  logic [1:0] state_led;

  operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw             (sw),
    .op_sw          (op_sw),
    .key_n          (key_n),
    .a              (a),
    .b              (b),
    .op             (op),
    .operands_valid (operands_valid),
    .state_led      (state_led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] op;
    logic       v;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  exp_t m   = '0;
  int   m_step = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference: the n-th accepted press (mod 4) loads A, loads B, loads op
  // and sets valid, or drops valid.
  function automatic void model_press(input logic [2:0] s, input logic [1:0] o);
    case (m_step)
      0:       m.a = s;
      1:       m.b = s;
      2:       begin m.op = o; m.v = 1'b1; end
      default: m.v = 1'b0;
    endcase
    m_step = (m_step + 1) % 4;
    m.st   = 2'(m_step);
    q.push_back(m);
  endfunction

  function automatic void model_reset();
    m      = '0;
    m_step = 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input exp_t d, input exp_t e);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s @%0t: got a=%0d b=%0d op=%0d v=%0d st=%0d expected a=%0d b=%0d op=%0d v=%0d st=%0d",
               name, $time, d.a, d.b, d.op, d.v, d.st, e.a, e.b, e.op, e.v, e.st);
    end
  endtask

  // Monitor: every state change must match the next expected capture;
  // between changes the outputs must hold exactly.
  always @(negedge clk) begin
    exp_t d;
    d = {a, b, op, operands_valid, state_led};
    if (!rst_n) begin
      cur = '0;
    end else if (state_led != cur.st) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transition @%0t: state_led %0d, held %0d", $time, state_led, cur.st);
        cur = d;
      end else begin
        cur = q.pop_front();
        check_vec("capture", d, cur);
      end
    end else begin
      check_vec("hold", d, cur);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Optional bounce (random runs of 1..blen cycles, shorter than D), then a
  // clean fall held for `hold` cycles, then release and settle.
  task automatic press_key(input logic [2:0] s, input logic [1:0] o,
                           input int bounces, input int blen, input int hold);
    int n;
    bit done;
    logic [1:0] prev;
    sw    = s;
    op_sw = o;
    cyc(4);
    for (int i = 0; i < bounces; i++) begin
      key_n = 1'b0;
      cyc($urandom_range(1, blen));
      key_n = 1'b1;
      cyc($urandom_range(1, blen));
    end
    model_press(s, o);
    prev  = state_led;
    key_n = 1'b0;
    n     = 0;
    done  = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (state_led != prev) done = 1'b1;
    end
    check("press_latency", done ? n : -1, 2 + D + 1);
    @(posedge clk);
    #1;
    n++;
    while (n < hold) begin
      cyc(1);
      n++;
    end
    key_n = 1'b1;
    cyc(D + 8);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    sw    = 3'd0;
    op_sw = 2'd0;
    #12;
    check("reset_a", a, 0);
    check("reset_state", state_led, 0);
    check("reset_valid", operands_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: idle
    cyc(50);
    check("idle_a", a, 0);
    check("idle_b", b, 0);
    check("idle_op", op, 0);
    check("idle_valid", operands_valid, 0);
    check("idle_state", state_led, 0);

    // 2: A=5, B=3, op=1
    press_key(3'd5, 2'd0, 0, 1, 10);
    press_key(3'd3, 2'd2, 0, 1, 10);
    press_key(3'd6, 2'd1, 0, 1, 10);
    check("load_a", a, 5);
    check("load_b", b, 3);
    check("load_op", op, 1);
    check("load_valid", operands_valid, 1);
    check("load_state", state_led, 3);

    // 4: press in READY drops valid, keeps operands
    press_key(3'd7, 2'd3, 0, 1, 10);
    check("ready_valid", operands_valid, 0);
    check("ready_state", state_led, 0);
    check("ready_a", a, 5);
    check("ready_b", b, 3);

    // 3: 1-cycle bounce for 20 cycles, then held low
    press_key(3'd4, 2'd2, 10, 1, 12);
    check("bounce_state", state_led, 1);
    check("bounce_a", a, 4);
    check("bounce_b", b, 3);

    // 5: reset in WAIT_OP while debouncing a held key
    press_key(3'd2, 2'd0, 0, 1, 10);
    check("pre_reset_state", state_led, 2);
    sw    = 3'd1;
    key_n = 1'b0;
    cyc(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_a", a, 0);
    check("async_b", b, 0);
    check("async_op", op, 0);
    check("async_valid", operands_valid, 0);
    check("async_state", state_led, 0);
    model_reset();
    cyc(3);
    rst_n = 1'b0;
    rst_n = 1'b1;
    cyc(30);
    check("held_state", state_led, 0);
    check("held_a", a, 0);
    key_n = 1'b1;
    cyc(D + 8);
    press_key(3'd6, 2'd3, 0, 1, 10);
    check("post_reset_a", a, 6);

    // 6: long hold, release changes nothing
    press_key(3'd1, 2'd2, 0, 1, 100);
    cyc(20);
    check("long_hold_state", state_led, 2);
    check("long_hold_b", b, 1);

    // random sequence, with bounce runs shorter than the debounce window
    for (int i = 0; i < 14; i++)
      press_key(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 4), D - 1, $urandom_range(8, 30));
    cyc(20);
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
